// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the WISC pipelined control unit.
package ctrl_pkg;

    localparam int STAGES = 3;  // ID/EX, EX/MEM, MEM/WB

    // Single opcodes (low 5 bits of instr[15:11])
    localparam logic [4:0] OP_HALT   = 5'b00000;
    localparam logic [4:0] OP_NOP    = 5'b00001;
    localparam logic [4:0] OP_SIIC   = 5'b00010;
    localparam logic [4:0] OP_RTI    = 5'b00011;
    localparam logic [4:0] OP_J      = 5'b00100;
    localparam logic [4:0] OP_JR     = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b00110;
    localparam logic [4:0] OP_JALR   = 5'b00111;
    localparam logic [4:0] OP_ST     = 5'b10000;
    localparam logic [4:0] OP_LD     = 5'b10001;
    localparam logic [4:0] OP_SLBI   = 5'b10010;
    localparam logic [4:0] OP_STU    = 5'b10011;
    localparam logic [4:0] OP_LBI    = 5'b11000;
    localparam logic [4:0] OP_BTR    = 5'b11001;
    localparam logic [4:0] OP_RSHIFT = 5'b11010;  // ROL/SLL/ROR/SRL, funct picks
    localparam logic [4:0] OP_RARITH = 5'b11011;  // ADD/SUB/XOR/ANDN, funct picks

    // Four-opcode groups, keyed by op[4:2]; op[1:0] selects within the group
    localparam logic [2:0] GRP_IARITH = 3'b010;  // ADDI SUBI XORI ANDNI
    localparam logic [2:0] GRP_BR     = 3'b011;  // BEQZ BNEZ BLTZ BGEZ
    localparam logic [2:0] GRP_ISHIFT = 3'b101;  // ROLI SLLI RORI SRLI
    localparam logic [2:0] GRP_SET    = 3'b111;  // SEQ SLT SLE SCO

    // ALU encodings; group prefixes take op[1:0] as the low bits
    localparam logic [3:0] ALU_PASSB = 4'b0000;
    localparam logic [3:0] ALU_SLBI  = 4'b0001;
    localparam logic [3:0] ALU_BTR   = 4'b0010;
    localparam logic [1:0] ALU_SET   = 2'b01;
    localparam logic [1:0] ALU_SHIFT = 2'b10;
    localparam logic [1:0] ALU_ARITH = 2'b11;
    localparam logic [3:0] ALU_SHL   = 4'b1000;  // shift group base (R-type uses funct)
    localparam logic [3:0] ALU_ADD   = 4'b1100;  // arith group base (R-type uses funct)
    localparam logic [3:0] ALU_BR    = 4'b1101;

    // Destination register select and writeback source
    localparam logic [1:0] RD_RD = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RS = 2'b10;
    localparam logic [1:0] RD_R7 = 2'b11;
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef struct packed {
        logic [1:0] reg_dst;
        logic [3:0] alu_op;
        logic [1:0] mem_to_reg;
        logic [1:0] br_cond;
        logic       alu_src;
        logic       sign_alu;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       is_halt;
        logic       is_siic;
        logic       is_rti;
        logic       illegal;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // Instructions that stop the core once they retire
    function automatic logic is_stop(ctrl_t c);
        return c.is_halt | c.illegal;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Front-end / datapath bus of the control pipe.
interface ctrl_pipe_if #(parameter int OP_W = 5);
    import ctrl_pkg::*;

    logic [OP_W-1:0] id_op;
    logic            id_valid;
    logic            stall;
    logic            flush;
    logic            fetch_en;
    ctrl_t           ex_ctrl;
    ctrl_t           mem_ctrl;
    ctrl_t           wb_ctrl;
    logic            ex_v;
    logic            mem_v;
    logic            wb_v;

    // Fetch/decode and hazard logic side
    modport master (
        output id_op, id_valid, stall, flush,
        input  fetch_en, ex_ctrl, mem_ctrl, wb_ctrl, ex_v, mem_v, wb_v
    );

    // Control unit side
    modport slave (
        input  id_op, id_valid, stall, flush,
        output fetch_en, ex_ctrl, mem_ctrl, wb_ctrl, ex_v, mem_v, wb_v
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational WISC opcode -> control word decoder.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter bit EXC_EN = 1'b1
) (
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);
    logic [4:0] op5;
    logic       hi_bad;

    assign op5 = op[4:0];

    generate
        if (OP_W > 5) begin : g_hi
            assign hi_bad = |op[OP_W-1:5];
        end else begin : g_nohi
            assign hi_bad = 1'b0;
        end
    endgenerate

    // Every path starts from an all-zero word, so no X reaches the pipe.
    always_comb begin
        ctrl = '0;
        if (hi_bad) begin
            ctrl.illegal = 1'b1;
        end else begin
            case (op5)
                OP_HALT: ctrl.is_halt = 1'b1;
                OP_NOP:  ;
                OP_SIIC: ctrl.is_siic = EXC_EN;  // NOP when exceptions are off
                OP_RTI:  ctrl.is_rti  = EXC_EN;
                OP_J:    ctrl.jump    = 1'b1;
                OP_JR: begin
                    ctrl.jump    = 1'b1;
                    ctrl.alu_src = 1'b1;
                    ctrl.alu_op  = ALU_ADD;
                end
                OP_JAL: begin
                    ctrl.jump       = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_R7;
                    ctrl.mem_to_reg = WB_PC;
                end
                OP_JALR: begin
                    ctrl.jump       = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_R7;
                    ctrl.mem_to_reg = WB_PC;
                end
                OP_ST: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.sign_alu  = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                OP_LD: begin
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.sign_alu   = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_read   = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = RD_RT;
                    ctrl.mem_to_reg = WB_MEM;
                end
                OP_STU: begin
                    // Store that also writes the updated address back to Rs
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.sign_alu  = 1'b1;
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RS;
                end
                OP_SLBI: begin
                    ctrl.alu_op    = ALU_SLBI;
                    ctrl.alu_src   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RS;
                end
                OP_LBI: begin
                    ctrl.alu_op    = ALU_PASSB;
                    ctrl.alu_src   = 1'b1;
                    ctrl.sign_alu  = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RS;
                end
                OP_BTR: begin
                    ctrl.alu_op    = ALU_BTR;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RD;
                end
                OP_RSHIFT: begin
                    ctrl.alu_op    = ALU_SHL;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RD;
                end
                OP_RARITH: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = RD_RD;
                end
                default: begin
                    case (op5[4:2])
                        GRP_IARITH: begin
                            ctrl.alu_op    = {ALU_ARITH, op5[1:0]};
                            ctrl.sign_alu  = 1'b1;
                            ctrl.alu_src   = 1'b1;
                            ctrl.reg_write = 1'b1;
                            ctrl.reg_dst   = RD_RT;
                        end
                        GRP_BR: begin
                            ctrl.branch  = 1'b1;
                            ctrl.alu_op  = ALU_BR;
                            ctrl.br_cond = op5[1:0];
                        end
                        GRP_ISHIFT: begin
                            ctrl.alu_op    = {ALU_SHIFT, op5[1:0]};
                            ctrl.alu_src   = 1'b1;
                            ctrl.reg_write = 1'b1;
                            ctrl.reg_dst   = RD_RT;
                        end
                        GRP_SET: begin
                            ctrl.alu_op    = {ALU_SET, op5[1:0]};
                            ctrl.reg_write = 1'b1;
                            ctrl.reg_dst   = RD_RD;
                        end
                        default: ctrl.illegal = 1'b1;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decode in ID, carry control words to EX/MEM/WB,
// stall/flush handling, halt drain and SIIC/RTI exception tracking.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W   = 5,
    parameter bit EXC_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus,
    output logic         halt,
    output logic         err,
    output logic         exc,
    output logic         in_exc
);
    ctrl_t                dec;
    ctrl_t                entry;
    ctrl_t                wb;
    ctrl_t [STAGES:1]     stage_ctrl;
    logic  [STAGES:1]     vld_pipe;
    state_t               state, state_nx;
    logic                 accept;
    logic                 set_halt, set_err, set_exc, clr_exc;

    ctrl_decode #(.OP_W(OP_W), .EXC_EN(EXC_EN)) u_dec (
        .op   (bus.id_op),
        .ctrl (dec)
    );

    // Flush kills ID and stall holds it; either leaves a bubble in EX.
    always_comb begin
        accept = bus.id_valid & ~bus.stall & ~bus.flush & (state == RUN);
        entry  = accept ? dec : '0;
        wb     = stage_ctrl[STAGES];
    end

    // A HALT sitting in ID stops fetch at once so nothing younger follows it.
    always_comb begin
        bus.fetch_en = ~bus.stall & (state == RUN) & ~(bus.id_valid & dec.is_halt);
    end

    assign bus.ex_v     = vld_pipe[1];
    assign bus.mem_v    = vld_pipe[2];
    assign bus.wb_v     = vld_pipe[3];
    assign bus.ex_ctrl  = stage_ctrl[1];
    assign bus.mem_ctrl = stage_ctrl[2];
    assign bus.wb_ctrl  = stage_ctrl[3];

    // Stage registers advance every cycle; bubbles carry an all-zero word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            stage_ctrl <= '0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:1], accept};
            stage_ctrl <= {stage_ctrl[STAGES-1:1], entry};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nx;
    end

    // Next state plus sticky-flag set/clear strobes
    always_comb begin
        state_nx = state;
        set_halt = 1'b0;
        set_err  = 1'b0;
        set_exc  = 1'b0;
        clr_exc  = 1'b0;
        case (state)
            RUN: begin
                if (accept && is_stop(dec)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (vld_pipe[3] && is_stop(wb)) begin
                    state_nx = HALTED;
                    set_halt = 1'b1;
                    set_err  = wb.illegal;
                end
            end
            default: ;
        endcase
        // Exceptions retire in WB; a nested SIIC is fatal and overrides the above.
        if (EXC_EN && state != HALTED && vld_pipe[3]) begin
            if (wb.is_siic) begin
                if (in_exc) begin
                    state_nx = HALTED;
                    set_halt = 1'b1;
                    set_err  = 1'b1;
                end else begin
                    set_exc = 1'b1;
                end
            end
            if (wb.is_rti) clr_exc = 1'b1;
        end
    end

    // Sticky status flags and the one-cycle exception pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt   <= 1'b0;
            err    <= 1'b0;
            exc    <= 1'b0;
            in_exc <= 1'b0;
        end else begin
            exc <= set_exc;
            if (set_halt) halt <= 1'b1;
            if (set_err)  err  <= 1'b1;
            if (set_exc)      in_exc <= 1'b1;
            else if (clr_exc) in_exc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized bench for ctrl_pipe against an opcode-table pipeline model.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic halt, err, exc, in_exc;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state
    bit    m_v [1:3];
    ctrl_t m_c [1:3];
    bit    m_drain, m_halted, m_halt, m_err, m_exc, m_inexc;

    ctrl_pipe_if #(.OP_W(6)) bus ();

    ctrl_pipe #(.OP_W(6), .EXC_EN(1'b1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .halt   (halt),
        .err    (err),
        .exc    (exc),
        .in_exc (in_exc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference control word, written per WISC mnemonic (opcode given in decimal)
    function automatic ctrl_t ref_ctrl(input logic [5:0] op);
        ctrl_t c = '0;
        int o;
        if (op[5]) begin
            c.illegal = 1'b1;
            return c;
        end
        o = int'(op[4:0]);
        case (o) inside
            0: c.is_halt = 1'b1;
            1: ;
            2: c.is_siic = 1'b1;
            3: c.is_rti = 1'b1;
            4: c.jump = 1'b1;
            5: begin c.jump = 1; c.alu_src = 1; c.alu_op = 4'd12; end
            6: begin c.jump = 1; c.reg_write = 1; c.reg_dst = 2'd3; c.mem_to_reg = 2'd2; end
            7: begin c.jump = 1; c.alu_src = 1; c.alu_op = 4'd12;
                      c.reg_write = 1; c.reg_dst = 2'd3; c.mem_to_reg = 2'd2; end
            [8:11]: begin c.alu_op = 4'(12 + o - 8); c.sign_alu = 1; c.alu_src = 1;
                          c.reg_write = 1; c.reg_dst = 2'd1; end
            [12:15]: begin c.branch = 1; c.alu_op = 4'd13; c.br_cond = 2'(o - 12); end
            16: begin c.alu_op = 4'd12; c.sign_alu = 1; c.alu_src = 1; c.mem_write = 1; end
            17: begin c.alu_op = 4'd12; c.sign_alu = 1; c.alu_src = 1; c.mem_read = 1;
                      c.reg_write = 1; c.reg_dst = 2'd1; c.mem_to_reg = 2'd1; end
            18: begin c.alu_op = 4'd1; c.alu_src = 1; c.reg_write = 1; c.reg_dst = 2'd2; end
            19: begin c.alu_op = 4'd12; c.sign_alu = 1; c.alu_src = 1; c.mem_write = 1;
                      c.reg_write = 1; c.reg_dst = 2'd2; end
            [20:23]: begin c.alu_op = 4'(8 + o - 20); c.alu_src = 1; c.reg_write = 1;
                           c.reg_dst = 2'd1; end
            24: begin c.alu_op = 4'd0; c.alu_src = 1; c.sign_alu = 1; c.reg_write = 1;
                      c.reg_dst = 2'd2; end
            25: begin c.alu_op = 4'd2; c.reg_write = 1; end
            26: begin c.alu_op = 4'd8; c.reg_write = 1; end
            27: begin c.alu_op = 4'd12; c.reg_write = 1; end
            default: begin c.alu_op = 4'(4 + o - 28); c.reg_write = 1; end
        endcase
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 1; i <= 3; i++) begin
            m_v[i] = 1'b0;
            m_c[i] = '0;
        end
        m_drain = 0; m_halted = 0; m_halt = 0; m_err = 0; m_exc = 0; m_inexc = 0;
    endtask

    task automatic check_outs();
        chk("ex_v",     32'(bus.ex_v),     32'(m_v[1]));
        chk("mem_v",    32'(bus.mem_v),    32'(m_v[2]));
        chk("wb_v",     32'(bus.wb_v),     32'(m_v[3]));
        chk("ex_ctrl",  32'(bus.ex_ctrl),  32'(m_c[1]));
        chk("mem_ctrl", 32'(bus.mem_ctrl), 32'(m_c[2]));
        chk("wb_ctrl",  32'(bus.wb_ctrl),  32'(m_c[3]));
        chk("halt",     32'(halt),         32'(m_halt));
        chk("err",      32'(err),          32'(m_err));
        chk("exc",      32'(exc),          32'(m_exc));
        chk("in_exc",   32'(in_exc),       32'(m_inexc));
    endtask

    // One clock: drive at negedge, check fetch_en, advance model at posedge, check outputs.
    task automatic step(input logic [5:0] op, input logic v, input logic st, input logic fl);
        ctrl_t dc, wbc;
        bit    run, acc, fe;
        @(negedge clk);
        bus.id_op = op; bus.id_valid = v; bus.stall = st; bus.flush = fl;
        #1;
        dc  = ref_ctrl(op);
        run = !m_halted && !m_drain;
        fe  = !st && run && !(v && dc.is_halt);
        chk("fetch_en", 32'(bus.fetch_en), 32'(fe));
        @(posedge clk);
        acc   = v && !st && !fl && run;
        m_exc = 0;
        wbc   = m_c[3];
        if (!m_halted && m_v[3]) begin
            if (wbc.is_halt || wbc.illegal) begin
                m_halted = 1; m_halt = 1;
                if (wbc.illegal) m_err = 1;
            end
            if (wbc.is_siic) begin
                if (m_inexc) begin m_err = 1; m_halt = 1; m_halted = 1; end
                else begin m_exc = 1; m_inexc = 1; end
            end
            if (wbc.is_rti) m_inexc = 0;
        end
        if (acc && (dc.is_halt || dc.illegal)) m_drain = 1;
        m_v[3] = m_v[2]; m_c[3] = m_c[2];
        m_v[2] = m_v[1]; m_c[2] = m_c[1];
        m_v[1] = acc;    m_c[1] = acc ? dc : '0;
        #1;
        cyc++;
        check_outs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(6'd1, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges so its effect is visibly asynchronous.
    task automatic do_reset();
        @(negedge clk);
        bus.id_op = 6'd1; bus.id_valid = 0; bus.stall = 0; bus.flush = 0;
        #3;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outs();
        @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_en_rel", 32'(bus.fetch_en), 32'd1);
    endtask

    initial begin
        logic [5:0] op;
        int r;
        bus.id_op = 6'd1; bus.id_valid = 0; bus.stall = 0; bus.flush = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("fetch_en_rst", 32'(bus.fetch_en), 32'd1);

        // ADDI: visible in EX next edge, WB three edges after acceptance
        step(6'd8, 1, 0, 0);
        chk("addi_alu_op",  32'(bus.ex_ctrl.alu_op),    32'hC);
        chk("addi_alu_src", 32'(bus.ex_ctrl.alu_src),   32'd1);
        chk("addi_rw",      32'(bus.ex_ctrl.reg_write), 32'd1);
        idle(2);
        chk("addi_wb_v",    32'(bus.wb_v),              32'd1);

        // LD then two stall cycles -> two bubbles
        step(6'd17, 1, 0, 0);
        step(6'd8, 1, 1, 0);
        chk("stall_bubble1", 32'(bus.ex_v), 32'd0);
        step(6'd8, 1, 1, 0);
        chk("stall_bubble2", 32'(bus.ex_v), 32'd0);
        step(6'd8, 1, 0, 0);
        chk("stall_release", 32'(bus.ex_v), 32'd1);

        // Stall + flush with BEQZ: flush wins, then BEQZ enters
        step(6'd12, 1, 1, 1);
        chk("flush_bubble", 32'(bus.ex_v), 32'd0);
        step(6'd12, 1, 0, 0);
        chk("beqz_branch", 32'(bus.ex_ctrl.branch),  32'd1);
        chk("beqz_cond",   32'(bus.ex_ctrl.br_cond), 32'd0);

        // HALT then ADD: ADD never enters, halt after retire
        step(6'd0, 1, 0, 0);
        step(6'd27, 1, 0, 0);
        step(6'd27, 1, 0, 0);
        step(6'd27, 1, 0, 0);
        chk("halt_set",  32'(halt),       32'd1);
        chk("halt_vals", 32'({bus.ex_v, bus.mem_v, bus.wb_v}), 32'd0);
        step(6'd27, 1, 0, 0);

        // Illegal opcode (upper bit set)
        do_reset();
        step(6'h3F, 1, 0, 0);
        idle(3);
        chk("ill_err",  32'(err),  32'd1);
        chk("ill_halt", 32'(halt), 32'd1);

        // SIIC, SIIC: one exc pulse, then err
        do_reset();
        step(6'd2, 1, 0, 0);
        step(6'd2, 1, 0, 0);
        idle(2);
        chk("siic_exc", 32'(exc), 32'd1);
        idle(1);
        chk("siic_exc_off", 32'(exc), 32'd0);
        chk("siic_err",     32'(err), 32'd1);

        // Reset while draining with a full pipe and in_exc set
        do_reset();
        step(6'd2, 1, 0, 0);
        step(6'd1, 1, 0, 0);
        step(6'd1, 1, 0, 0);
        step(6'd0, 1, 0, 0);
        chk("pre_rst_in_exc", 32'(in_exc), 32'd1);
        chk("pre_rst_full", 32'({bus.ex_v, bus.mem_v, bus.wb_v}), 32'h7);
        do_reset();

        // Randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            int settle = 0;
            do_reset();
            for (int n = 0; n < 80; n++) begin
                r = $urandom_range(0, 99);
                if (r < 2)       op = 6'd0;
                else if (r < 4)  op = 6'h20 | 6'($urandom_range(0, 31));
                else if (r < 10) op = 6'd2;
                else if (r < 16) op = 6'd3;
                else             op = 6'($urandom_range(1, 31));
                step(op, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 15),
                     ($urandom_range(0, 99) < 10));
                if (m_halted) settle++;
                if (settle > 4) break;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
